// File: rtl/umi_arbiter_pkg.sv
// Shared UMI arbiter constants: arbitration mode encodings and a pointer-width helper.
// Latency: n/a (constants only).
// Backpressure: n/a.
package umi_arbiter_pkg;

  // Arbitration mode encodings carried on the mode input
  localparam logic UMI_ARB_RR    = 1'b0;
  localparam logic UMI_ARB_FIXED = 1'b1;

  // Width of an index into n requesters; never narrower than one bit
  function automatic int umi_ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/umi_arbiter_core.sv
// Grant selection over the request vector: round-robin from ptr+1 or fixed lowest-index priority.
// Latency: purely combinational, same-cycle grant.
// Backpressure: none here; the caller qualifies grant with its load enable.
module umi_arbiter_core
  import umi_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = umi_ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  // Pick the first requester in search order; grant stays one-hot or zero
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (mode == UMI_ARB_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      // Search starts just past the last winner and wraps, so the last winner is tried last
      for (int k = 1; k <= N; k++) begin
        idx = PW'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/umi_arbiter.sv
// N-to-1 UMI arbiter merging requester beats into one registered output stage.
// Latency: 1 cycle from input handshake to umi_out_valid; 1 beat/cycle while umi_out_ready=1.
// Backpressure: umi_in_ready is held low while the output register is full and not draining.
module umi_arbiter
  import umi_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 64,
  parameter int CW = 32,
  parameter int DW = 256
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            mode,
  input  logic [N-1:0]    mask,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  localparam int PW = umi_ptr_width(N);

  logic          load_en;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          xfer;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [CW-1:0] mux_cmd;
  logic [AW-1:0] mux_dstaddr;
  logic [AW-1:0] mux_srcaddr;
  logic [DW-1:0] mux_data;

  // The output register can take a new beat when empty or draining this cycle
  assign load_en = ~umi_out_valid | umi_out_ready;
  assign req     = umi_in_valid & ~mask;

  umi_arbiter_core #(
    .N  (N),
    .PW (PW)
  ) u_core (
    .req   (req),
    .ptr   (ptr),
    .mode  (mode),
    .grant (grant)
  );

  // Ready is forced low during reset so nothing handshakes into a register being cleared
  assign umi_in_ready = (nreset && load_en) ? grant : '0;
  assign xfer         = |(umi_in_valid & umi_in_ready);

  // AND-OR payload select and index encode from the one-hot grant
  always_comb begin
    mux_cmd     = '0;
    mux_dstaddr = '0;
    mux_srcaddr = '0;
    mux_data    = '0;
    gnt_idx     = '0;
    for (int i = 0; i < N; i++) begin
      mux_cmd     = mux_cmd     | ({CW{grant[i]}} & umi_in_cmd[i*CW +: CW]);
      mux_dstaddr = mux_dstaddr | ({AW{grant[i]}} & umi_in_dstaddr[i*AW +: AW]);
      mux_srcaddr = mux_srcaddr | ({AW{grant[i]}} & umi_in_srcaddr[i*AW +: AW]);
      mux_data    = mux_data    | ({DW{grant[i]}} & umi_in_data[i*DW +: DW]);
      gnt_idx     = gnt_idx     | ({PW{grant[i]}} & PW'(i));
    end
  end

  // Round-robin pointer follows the last winner; reset value gives requester 0 first turn
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr <= PW'(N - 1);
    end else if (xfer) begin
      ptr <= gnt_idx;
    end
  end

  // Output stage: load on transfer, empty when drained, otherwise hold the beat
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      umi_out_valid   <= 1'b0;
      umi_out_cmd     <= '0;
      umi_out_dstaddr <= '0;
      umi_out_srcaddr <= '0;
      umi_out_data    <= '0;
    end else if (xfer) begin
      umi_out_valid   <= 1'b1;
      umi_out_cmd     <= mux_cmd;
      umi_out_dstaddr <= mux_dstaddr;
      umi_out_srcaddr <= mux_srcaddr;
      umi_out_data    <= mux_data;
    end else if (umi_out_ready) begin
      umi_out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_umi_arbiter.sv
// Self-checking bench for umi_arbiter: directed scenarios then randomized traffic vs a reference model.
// Latency: model expects each accepted beat on the output one cycle after its handshake.
// Backpressure: model expects no ready while the output holds an undrained beat.
module tb_umi_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int CW = 32;
  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            nreset;
  logic            mode;
  logic [N-1:0]    mask;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_valid;
  logic [CW-1:0] m_cmd;
  logic [AW-1:0] m_dst;
  logic [AW-1:0] m_src;
  logic [DW-1:0] m_data;
  int            m_ptr;

  // Values sampled by the last tick for directed checks
  logic [N-1:0]  last_rdy;
  logic          last_out_fire;
  logic [CW-1:0] last_out_cmd;

  always #5 clk = ~clk;

  umi_arbiter #(.N(N), .AW(AW), .CW(CW), .DW(DW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .mode            (mode),
    .mask            (mask),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner from the rules: fixed = lowest index, round-robin = first after ptr with wrap
  function automatic int ref_grant(input logic [N-1:0] r, input logic md, input int p);
    if (md) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_cmd   = '0;
    m_dst   = '0;
    m_src   = '0;
    m_data  = '0;
    m_ptr   = N - 1;
  endtask

  // Directed payloads tag cmd with 0x10+requester; addresses and data are always random
  task automatic drive_payload(input bit directed);
    for (int i = 0; i < N; i++) begin
      umi_in_cmd[i*CW +: CW]     = directed ? (32'h10 + 32'(i)) : $urandom;
      umi_in_dstaddr[i*AW +: AW] = {$urandom, $urandom};
      umi_in_srcaddr[i*AW +: AW] = {$urandom, $urandom};
      for (int w = 0; w < DW/32; w++) umi_in_data[i*DW + w*32 +: 32] = $urandom;
    end
  endtask

  // One cycle: called at a negedge with inputs set; checks, then advances the model across posedge
  task automatic tick();
    int g;
    logic [N-1:0] e;
    #1;
    g = ref_grant(umi_in_valid & ~mask, mode, m_ptr);
    e = '0;
    if (g >= 0 && (!m_valid || umi_out_ready)) e[g] = 1'b1;
    last_rdy      = umi_in_ready;
    last_out_fire = umi_out_valid & umi_out_ready;
    last_out_cmd  = umi_out_cmd;
    chk("in_ready",  DW'(umi_in_ready),    DW'(e));
    chk("out_valid", DW'(umi_out_valid),   DW'(m_valid));
    chk("out_cmd",   DW'(umi_out_cmd),     DW'(m_cmd));
    chk("out_dst",   DW'(umi_out_dstaddr), DW'(m_dst));
    chk("out_src",   DW'(umi_out_srcaddr), DW'(m_src));
    chk("out_data",  umi_out_data,         m_data);
    @(posedge clk);
    if (e != '0) begin
      m_cmd   = umi_in_cmd[g*CW +: CW];
      m_dst   = umi_in_dstaddr[g*AW +: AW];
      m_src   = umi_in_srcaddr[g*AW +: AW];
      m_data  = umi_in_data[g*DW +: DW];
      m_valid = 1'b1;
      m_ptr   = g;
    end else if (umi_out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int consumed;

    // Reset state, with valid already asserted
    nreset        = 1'b0;
    mode          = 1'b0;
    mask          = '0;
    umi_in_valid  = '1;
    umi_out_ready = 1'b1;
    drive_payload(1'b1);
    model_reset();
    #3;
    chk("rst_out_valid", DW'(umi_out_valid), '0);
    chk("rst_in_ready",  DW'(umi_in_ready),  '0);
    chk("rst_out_data",  umi_out_data,       '0);
    chk("rst_out_cmd",   DW'(umi_out_cmd),   '0);
    @(negedge clk);
    nreset = 1'b1;

    // Round-robin, all valid: sources 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      drive_payload(1'b1);
      tick();
      chk("rr_src", DW'(umi_out_cmd), DW'(32'h10 + 32'(k % 4)));
    end

    // Fixed priority with requester 0 idle: requester 1 always wins
    mode = 1'b1;
    umi_in_valid = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      drive_payload(1'b1);
      tick();
      chk("fixed_rdy", DW'(last_rdy),    DW'(4'b0010));
      chk("fixed_src", DW'(umi_out_cmd), DW'(32'h11));
    end

    // Stall with requester 2's beat held; next grant after release goes to 3
    mode = 1'b0;
    umi_in_valid = '1;
    drive_payload(1'b1);
    tick();
    chk("stall_load", DW'(umi_out_cmd), DW'(32'h12));
    umi_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_payload(1'b1);
      tick();
      chk("stall_rdy", DW'(last_rdy),    '0);
      chk("stall_cmd", DW'(umi_out_cmd), DW'(32'h12));
    end
    umi_out_ready = 1'b1;
    drive_payload(1'b1);
    tick();
    chk("release_rdy", DW'(last_rdy),    DW'(4'b1000));
    chk("release_cmd", DW'(umi_out_cmd), DW'(32'h13));

    // Mask 0101: grants alternate 1,3; unmasking takes effect the same cycle
    mask = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      drive_payload(1'b1);
      tick();
      chk("mask_src", DW'(umi_out_cmd), DW'((k % 2 == 0) ? 32'h11 : 32'h13));
    end
    mask = '0;
    drive_payload(1'b1);
    tick();
    chk("unmask_rdy", DW'(last_rdy), DW'(4'b0001));

    // Asynchronous reset while a beat is held
    #2 nreset = 1'b0;
    #1;
    chk("arst_out_valid", DW'(umi_out_valid), '0);
    chk("arst_out_data",  umi_out_data,       '0);
    chk("arst_out_cmd",   DW'(umi_out_cmd),   '0);
    chk("arst_in_ready",  DW'(umi_in_ready),  '0);
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    drive_payload(1'b1);
    tick();
    chk("post_rst_rdy", DW'(last_rdy), DW'(4'b0001));

    // Drain, then stream from requester 3 alone with out_ready toggling
    umi_in_valid = '0;
    tick();
    sent     = 0;
    consumed = 0;
    umi_in_valid = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      umi_out_ready = (k % 2 == 0);
      drive_payload(1'b1);
      umi_in_cmd[3*CW +: CW] = 32'h300 + 32'(sent);
      tick();
      if (last_out_fire) begin
        chk("stream_order", DW'(last_out_cmd), DW'(32'h300 + 32'(consumed)));
        consumed++;
      end
      if (last_rdy[3]) sent++;
    end
    chk("stream_progress", DW'(consumed >= 3), DW'(1'b1));

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      mode          = $urandom_range(0, 1) == 1;
      mask          = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      umi_in_valid  = N'($urandom_range(0, 15));
      umi_out_ready = $urandom_range(0, 3) != 0;
      drive_payload(1'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
